mmio_slot_fabric: RTL

- Parametrised MMIO slot interconnect for the FPro bus, sitting between the CPU-side MMIO port and N_SLOTS I/O cores.
- Decodes the slot field of the address and drives per-slot strobes.
- Unlike the fixed zero-wait controller, it supports per-slot wait states through a slot_ready handshake, registers read data, and flags bus errors.
- Unpopulated slots complete immediately with zero data and raise an error.

---
 rtl/mmio_fabric_pkg.sv | 32 +++
 rtl/mmio_slot_decoder.sv | 26 ++
 rtl/mmio_slot_fabric.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mmio_fabric_pkg.sv
// mmio_fabric_pkg: shared types, constants and address-field helpers for the
// MMIO slot fabric.
//   state_t     - fabric FSM encoding (IDLE, STROBE, WAIT, DONE)
//   ERR_DATA    - read data returned when a slot wait is forcibly ended
//   slot_field  - slot-select field of a bus word address (right-aligned)
//   reg_field   - per-slot register field of a bus word address
// Optional feature macro used by the fabric: MMIO_FABRIC_TIMEOUT_EN.
package mmio_fabric_pkg;

    localparam int ADDR_W = 21;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Caller truncates the result to its slot-field width.
    function automatic logic [ADDR_W-1:0] slot_field(input logic [ADDR_W-1:0] addr,
                                                     input int reg_w);
        return addr >> reg_w;
    endfunction

    // Caller truncates the result to its register-field width.
    function automatic logic [ADDR_W-1:0] reg_field(input logic [ADDR_W-1:0] addr,
                                                    input int reg_w);
        return addr & ((ADDR_W'(1) << reg_w) - ADDR_W'(1));
    endfunction

endpackage

// File: rtl/mmio_slot_decoder.sv
// mmio_slot_decoder: combinational one-hot decode of a slot index.
// Ports:
//   slot_idx     in  SLOT_W   slot index
//   slot_oh      out N_SLOTS  one-hot select, all zero when out of range
//   out_of_range out 1        slot_idx >= N_SLOTS
module mmio_slot_decoder #(
    parameter int N_SLOTS = 64,
    parameter int SLOT_W  = 6
) (
    input  logic [SLOT_W-1:0]  slot_idx,
    output logic [N_SLOTS-1:0] slot_oh,
    output logic               out_of_range
);

    always_comb begin
        slot_oh      = '0;
        out_of_range = 1'b1;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (slot_idx == SLOT_W'(k)) begin
                slot_oh[k]   = 1'b1;
                out_of_range = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mmio_slot_fabric.sv
// mmio_slot_fabric: MMIO slot interconnect between the CPU-side FPro bus and
// N_SLOTS I/O cores, with per-slot wait states, registered read data and a
// sticky bus error flag.
// Optional feature: define MMIO_FABRIC_TIMEOUT_EN to force completion after
// TIMEOUT wait cycles (read data ERR_DATA, bus_err set).
// Ports:
//   clk, reset (async, active low)
//   mmio_cs/mmio_wr/mmio_rd/mmio_addr/mmio_wr_data  CPU request
//   mmio_rd_data/mmio_ready                          CPU completion
//   bus_err (sticky) / err_clr                       error flag and clear
//   slot_cs/slot_rd/slot_wr                          one-hot slot controls
//   slot_reg_addr/slot_wr_data                       latched, shared by all slots
//   slot_rd_data (flattened, slot k at [k*DW +: DW]) / slot_ready  slot returns
//   fsm_state                                        FSM state for observation
//
// Handshake: the master raises mmio_cs with mmio_rd or mmio_wr for at least
// the IDLE cycle and issues nothing further until mmio_ready pulses for one
// cycle; mmio_rd_data is valid in that cycle. Towards a slot, slot_rd/slot_wr
// pulse for exactly one cycle while slot_cs stays high until the slot reports
// slot_ready (sampled from the strobe cycle onward); slot data is taken in the
// cycle slot_ready is seen.
module mmio_slot_fabric
    import mmio_fabric_pkg::*;
#(
    parameter int N_SLOTS = 64,
    parameter int SLOT_W  = 6,
    parameter int REG_W   = 5,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mmio_cs,
    input  logic                  mmio_wr,
    input  logic                  mmio_rd,
    input  logic [20:0]           mmio_addr,
    input  logic [DW-1:0]         mmio_wr_data,
    output logic [DW-1:0]         mmio_rd_data,
    output logic                  mmio_ready,
    output logic                  bus_err,
    input  logic                  err_clr,
    output logic [N_SLOTS-1:0]    slot_cs,
    output logic [N_SLOTS-1:0]    slot_rd,
    output logic [N_SLOTS-1:0]    slot_wr,
    output logic [REG_W-1:0]      slot_reg_addr,
    output logic [DW-1:0]         slot_wr_data,
    input  logic [N_SLOTS*DW-1:0] slot_rd_data,
    input  logic [N_SLOTS-1:0]    slot_ready,
    output state_t                fsm_state
);

    state_t              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q;
    logic [REG_W-1:0]    reg_q;
    logic [DW-1:0]       wdata_q;
    logic [DW-1:0]       rd_data_q;
    logic                is_wr_q;
    logic                bus_err_q;

    logic [N_SLOTS-1:0]  slot_oh;
    logic                slot_oor;
    logic                req;
    logic [DW-1:0]       sel_data;
    logic                sel_ready;
    logic                capture;
    logic [DW-1:0]       capture_data;
    logic                err_set;
    logic                timed_out;

    assign req = mmio_cs & (mmio_rd | mmio_wr);

    mmio_slot_decoder #(
        .N_SLOTS (N_SLOTS),
        .SLOT_W  (SLOT_W)
    ) u_decoder (
        .slot_idx     (slot_q),
        .slot_oh      (slot_oh),
        .out_of_range (slot_oor)
    );

    // One-hot mux of the addressed slot's data and ready.
    always_comb begin
        sel_data  = '0;
        sel_ready = 1'b0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (slot_oh[k]) begin
                sel_data  = slot_rd_data[k*DW +: DW];
                sel_ready = slot_ready[k];
            end
        end
    end

`ifdef MMIO_FABRIC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt_q;

    // Counter holds the number of WAIT cycles already elapsed, so the
    // TIMEOUT-th WAIT cycle is the last one.
    assign timed_out = (wait_cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
        end else if (state_q == WAIT) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end else begin
            wait_cnt_q <= '0;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        capture      = 1'b0;
        capture_data = '0;
        err_set      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = STROBE;
                    // Conflicting op: treated as a write but flagged.
                    err_set = mmio_rd & mmio_wr;
                end
            end
            STROBE: begin
                if (slot_oor) begin
                    state_d      = DONE;
                    err_set      = 1'b1;
                    capture      = ~is_wr_q;
                    capture_data = '0;
                end else if (sel_ready) begin
                    state_d      = DONE;
                    capture      = ~is_wr_q;
                    capture_data = sel_data;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (sel_ready) begin
                    state_d      = DONE;
                    capture      = ~is_wr_q;
                    capture_data = sel_data;
                end else if (timed_out) begin
                    state_d      = DONE;
                    err_set      = 1'b1;
                    capture      = ~is_wr_q;
                    capture_data = DW'(ERR_DATA);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            reg_q     <= '0;
            wdata_q   <= '0;
            is_wr_q   <= 1'b0;
            rd_data_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req) begin
                slot_q  <= SLOT_W'(slot_field(mmio_addr, REG_W));
                reg_q   <= REG_W'(reg_field(mmio_addr, REG_W));
                wdata_q <= mmio_wr_data;
                is_wr_q <= mmio_wr;
            end
            if (capture) begin
                rd_data_q <= capture_data;
            end
            // Set wins over a simultaneous clear.
            if (err_set) begin
                bus_err_q <= 1'b1;
            end else if (err_clr) begin
                bus_err_q <= 1'b0;
            end
        end
    end

    // Slot controls decode straight from state so reset drops them at once.
    assign slot_cs       = (state_q == STROBE || state_q == WAIT) ? slot_oh : '0;
    assign slot_rd       = (state_q == STROBE && !is_wr_q) ? slot_oh : '0;
    assign slot_wr       = (state_q == STROBE &&  is_wr_q) ? slot_oh : '0;
    assign slot_reg_addr = reg_q;
    assign slot_wr_data  = wdata_q;
    assign mmio_ready    = (state_q == DONE);
    assign mmio_rd_data  = rd_data_q;
    assign bus_err       = bus_err_q;
    assign fsm_state     = state_q;

endmodule
